fifo_hs: RTL
============

Name: fifo_hs

Overview:
Parametrised successor to the team's basic psh/pop FIFO, with valid/ready handshakes on both sides and any DEPTH from 1 upward, including non-power-of-2 values. Adds an optional registered output stage, a synchronous flush, occupancy level, almost-full/almost-empty thresholds and a high-water mark. Used as the general-purpose buffer between pipeline stages and at block boundaries.

Parameters:
WIDTH, 4, data width in bits (>=1)
DEPTH, 2, total entry capacity, including the output register when OUT_REG=1 (>=1; >=2 when OUT_REG=1)
AF_LVL, DEPTH-1, afull asserts when level >= AF_LVL
AE_LVL, 1, aempty asserts when level <= AE_LVL
OUT_REG, 0, 0 = combinational read of the head entry; 1 = head entry held in a dedicated output flop
LW, $clog2(DEPTH+1), width of level and hwm (derived; do not override)

Ports:
clk  in  1  clock, all state changes on posedge
rst  in  1  asynchronous, active-high reset
in_val  in  1  write request
in_dat  in  WIDTH  write data
in_rdy  out  1  FIFO can accept an entry; equals !full
out_val  out  1  head entry valid
out_dat  out  WIDTH  head entry data
out_rdy  in  1  consumer accepts the head entry
flush  in  1  synchronous clear of all contents
level  out  LW  number of entries held (0..DEPTH)
afull  out  1  level >= AF_LVL
aempty  out  1  level <= AE_LVL
hwm  out  LW  maximum level reached since reset or last flush

Behaviour:
- Reset (async assert, sync release): level=0, hwm=0, pointers=0, out_val=0, in_rdy=1, aempty=1, afull=(AF_LVL==0), out_dat=0. Storage contents are don't-care apart from out_dat.
- push = in_val & in_rdy; pop = out_val & out_rdy. in_val must not combinationally depend on in_rdy.
- in_rdy = (level != DEPTH). No write-through when full: a pop in the same cycle does not free a slot until the next cycle.
- Level update: push&pop -> unchanged; push only -> +1; pop only -> -1. Level never exceeds DEPTH and never goes below 0 by construction.
- Pointers wrap at DEPTH-1 to 0, including for non-power-of-2 DEPTH.
- OUT_REG=0:
  - out_dat = storage[rptr]; out_val = (level != 0).
  - A push at edge N makes out_val=1 after edge N (1-cycle write-to-read latency).
  - out_dat equals 0 when empty after reset; otherwise the last-read value.
- OUT_REG=1:
  - out_val and out_dat come straight from flops.
  - When the output register is empty or being popped, it loads the oldest array entry, or in_dat directly if the array is empty and push=1.
  - Write-to-read latency is 1 cycle; there are no bubbles under continuous push/pop.
  - level counts the output register entry.
- DEPTH=1: single entry; in_rdy=!out_val. Push and pop in the same cycle is not possible, because in_rdy=0 while out_val=1.
- flush:
  - At the edge: level=0, out_val=0, hwm=0, pointers=0.
  - flush overrides any concurrent push or pop; the pushed data is discarded and the pop is not counted.
  - in_rdy=1 in the following cycle.
- afull and aempty are combinational from the registered level, with no extra latency.
- hwm: after each edge, hwm = max(hwm, level_next); cleared by flush and reset.
- Reset mid-operation: all state returns immediately (asynchronously) to the reset values; no partial transaction survives.
- FIFO order is strict; data is never duplicated or lost except by flush.

Test Plan:
- WIDTH=8, DEPTH=4, OUT_REG=0: push 0x11,0x22,0x33,0x44 with out_rdy=0 -> in_rdy=0 after 4th edge, level=4, afull=1, hwm=4. Then pop 4 -> data 0x11..0x44 in order, aempty=1 at level 1 and 0, in_rdy=1.
- DEPTH=4 full: in_val=1, out_rdy=1 for one cycle -> one pop, no push, level=3. Next cycle push and pop -> level stays 3, order preserved across pointer wrap.
- DEPTH=3 (non-power-of-2), OUT_REG=1, continuous push 0..19 with random out_rdy -> outputs exactly 0..19 in order, level never >3, no bubble when out_rdy held 1 and level>0.
- DEPTH=1: push 0xA5 -> out_val=1, in_rdy=0 next cycle; in_val held with out_rdy=1 -> 0xA5 popped, next push accepted the following cycle.
- level=3 with flush=1 and push=1 in the same cycle -> next cycle level=0, out_val=0, hwm=0, in_rdy=1; pushed word never appears at the output.
- rst asserted asynchronously mid-stream (level=2) -> outputs immediately at reset values without a clock edge. After release, push 0x7E -> out_dat=0x7E, level=1.

Source files
------------

// File: rtl/fifo_hs.sv
// fifo_hs: parametrised valid/ready FIFO. Any DEPTH >= 1, optional output flop,
// synchronous flush, occupancy level, almost-full/empty flags, high-water mark.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_val/in_dat/in_rdy     write side handshake (in_rdy = !full)
//   out_val/out_dat/out_rdy  read side handshake (head entry)
//   flush                    synchronous clear of all contents
//   level, afull, aempty     occupancy and threshold flags
//   hwm                      max level since reset or last flush
module fifo_hs #(
    parameter int WIDTH   = 4,
    parameter int DEPTH   = 2,
    parameter int AF_LVL  = DEPTH - 1,
    parameter int AE_LVL  = 1,
    parameter int OUT_REG = 0,
    parameter int LW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_val,
    input  logic [WIDTH-1:0] in_dat,
    output logic             in_rdy,
    output logic             out_val,
    output logic [WIDTH-1:0] out_dat,
    input  logic             out_rdy,
    input  logic             flush,
    output logic [LW-1:0]    level,
    output logic             afull,
    output logic             aempty,
    output logic [LW-1:0]    hwm
);

    // With an output flop, one entry lives outside the array.
    localparam int ND = (OUT_REG != 0) ? DEPTH - 1 : DEPTH;
    localparam int PW = (ND > 1) ? $clog2(ND) : 1;
    localparam logic [PW-1:0] PMAX = PW'(ND - 1);

    logic [WIDTH-1:0] mem [ND];
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic [LW-1:0]    hwm_q;
    logic             push;
    logic             pop;
    logic             arr_push;
    logic             arr_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PMAX) ? '0 : p + PW'(1);
    endfunction

    assign in_rdy = (level_q != LW'(DEPTH));
    assign push   = in_val & in_rdy;
    assign pop    = out_val & out_rdy;
    assign level  = level_q;
    assign hwm    = hwm_q;
    assign afull  = (int'(level_q) >= AF_LVL);
    assign aempty = (int'(level_q) <= AE_LVL);

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= '0;
            hwm_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else if (flush) begin
            level_q <= '0;
            hwm_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
        end else begin
            level_q <= level_d;
            if (level_d > hwm_q)
                hwm_q <= level_d;
            if (arr_push)
                wptr_q <= nxt(wptr_q);
            if (arr_pop)
                rptr_q <= nxt(rptr_q);
        end
    end

    // Storage needs no reset; pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (arr_push && !flush)
            mem[wptr_q] <= in_dat;
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic             ov_q;
            logic [WIDTH-1:0] od_q;
            logic             load;
            logic             arr_empty;

            assign arr_empty = (level_q == LW'(ov_q));
            assign load      = !ov_q | out_rdy;
            assign arr_pop   = load & !arr_empty;
            // Bypass the array when it is empty and the flop can take data.
            assign arr_push  = push & !(load & arr_empty);
            assign out_val   = ov_q;
            assign out_dat   = od_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ov_q <= 1'b0;
                    od_q <= '0;
                end else if (flush) begin
                    ov_q <= 1'b0;
                end else if (load) begin
                    if (!arr_empty) begin
                        ov_q <= 1'b1;
                        od_q <= mem[rptr_q];
                    end else if (push) begin
                        ov_q <= 1'b1;
                        od_q <= in_dat;
                    end else begin
                        ov_q <= 1'b0;
                    end
                end
            end
        end else begin : g_comb
            logic [WIDTH-1:0] last_q;

            assign arr_push = push;
            assign arr_pop  = pop;
            assign out_val  = (level_q != '0);
            // When empty, present the last word read instead of stale storage.
            assign out_dat  = out_val ? mem[rptr_q] : last_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst)
                    last_q <= '0;
                else if (pop && !flush)
                    last_q <= mem[rptr_q];
            end
        end
    endgenerate

endmodule
